// File: rtl/image_loader.sv
// image_loader
// Front end of the bilinear downscaler. It takes a byte stream made of a
// 7-byte header (width L/H, height L/H, scale L/H, mode) followed by
// width*height pixels. Pixels are written row-major into the shared image
// memory starting at address 0. When the image is complete the loader
// latches the configuration and pulses start_proc to the control unit.
// The loader drives the memory only while cu_busy is low; the external mux
// gives the memory to the loader whenever the control unit is idle.
//
// Optional feature, macro IMAGE_LOADER_CHECKSUM_EN:
//   The loader keeps an 8-bit running sum of the header and pixel bytes and
//   expects one trailing byte after the last pixel. The image is started
//   only if sum + trailing byte == 0 (mod 256); otherwise the loader goes
//   to the error state. When the macro is not defined there is no trailing
//   byte.
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   in_valid      stream byte valid
//   in_data       stream byte
//   in_ready      loader accepts a byte (transfer = in_valid && in_ready)
//   cu_busy       control unit busy; the loader stalls while it is high
//   mem_we        memory write enable
//   mem_addr      memory address (pixel index)
//   mem_data_out  memory write data
//   cfg_width     latched image width
//   cfg_height    latched image height
//   cfg_scale     latched scale (0x0080 = 1/2, 0x0100 = 1)
//   cfg_mode      latched mode (0 = sequential, 1 = SIMD)
//   start_proc    one-cycle start pulse to the control unit
//   load_done     one-cycle pulse after start_proc
//   err           sticky error flag
//   clr_err       clears err and returns to HDR (ERR state only)
//
// state | meaning
// ------+----------------------------------------------------------
// HDR   | collecting the 7 header bytes
// CHECK | one cycle: validate the header, latch cfg on success
// PIX   | writing pixels, one memory write per accepted byte
// CKSUM | waiting for the trailing checksum byte (feature build only)
// START | one cycle: start_proc is raised on the next cycle
// DONE  | one cycle: load_done is raised on the next cycle
// ERR   | header or checksum rejected; waits for clr_err

module image_loader #(
   parameter int ADDR_W     = 19,
   parameter int MAX_PIXELS = 262144,
   parameter int HDR_BYTES  = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              cu_busy,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data_out,
   output logic [15:0]       cfg_width,
   output logic [15:0]       cfg_height,
   output logic [15:0]       cfg_scale,
   output logic [7:0]        cfg_mode,
   output logic              start_proc,
   output logic              load_done,
   output logic              err,
   input  logic              clr_err
);

   localparam int HC_W = $clog2(HDR_BYTES);

   typedef enum logic [2:0] {
      S_HDR   = 3'd0,
      S_CHECK = 3'd1,
      S_PIX   = 3'd2,
      S_CKSUM = 3'd3,
      S_START = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [HC_W-1:0]   hdr_cnt_q, hdr_cnt_d;
   logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [31:0]       last_idx_q, last_idx_d;

   // raw header fields, only copied to cfg_* once the header is accepted
   logic [15:0]       hw_q, hw_d;
   logic [15:0]       hh_q, hh_d;
   logic [15:0]       hs_q, hs_d;
   logic [7:0]        hm_q, hm_d;

   logic [15:0]       cfg_width_q, cfg_width_d;
   logic [15:0]       cfg_height_q, cfg_height_d;
   logic [15:0]       cfg_scale_q, cfg_scale_d;
   logic [7:0]        cfg_mode_q, cfg_mode_d;

   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_data_q, mem_data_d;
   logic              start_q, start_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

`ifdef IMAGE_LOADER_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
`endif

   logic              xfer;
   logic [31:0]       total_w;
   logic              hdr_bad;

   always_comb begin
      in_ready = 1'b0;
      if (!cu_busy) begin
         case (state_q)
            S_HDR:   in_ready = 1'b1;
            S_PIX:   in_ready = 1'b1;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            S_CKSUM: in_ready = 1'b1;
`endif
            default: in_ready = 1'b0;
         endcase
      end
   end

   assign xfer = in_valid && in_ready;

   // 16x16 product cannot overflow 32 bits, so the size check is exact
   always_comb begin
      total_w = 32'(hw_q) * 32'(hh_q);
      hdr_bad = (hw_q < 16'd2) || (hh_q < 16'd2) || hw_q[0] || hh_q[0] ||
                (total_w > 32'(MAX_PIXELS)) ||
                !((hs_q == 16'h0080) || (hs_q == 16'h0100)) ||
                (hm_q > 8'd1);
   end

   always_comb begin
      state_d      = state_q;
      hdr_cnt_d    = hdr_cnt_q;
      pix_cnt_d    = pix_cnt_q;
      last_idx_d   = last_idx_q;
      hw_d         = hw_q;
      hh_d         = hh_q;
      hs_d         = hs_q;
      hm_d         = hm_q;
      cfg_width_d  = cfg_width_q;
      cfg_height_d = cfg_height_q;
      cfg_scale_d  = cfg_scale_q;
      cfg_mode_d   = cfg_mode_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      start_d      = 1'b0;
      done_d       = 1'b0;
      err_d        = err_q;
`ifdef IMAGE_LOADER_CHECKSUM_EN
      sum_d        = sum_q;
`endif

      case (state_q)
         S_HDR: begin
            if (xfer) begin
               case (hdr_cnt_q)
                  3'd0:    hw_d[7:0]  = in_data;
                  3'd1:    hw_d[15:8] = in_data;
                  3'd2:    hh_d[7:0]  = in_data;
                  3'd3:    hh_d[15:8] = in_data;
                  3'd4:    hs_d[7:0]  = in_data;
                  3'd5:    hs_d[15:8] = in_data;
                  default: hm_d       = in_data;
               endcase
`ifdef IMAGE_LOADER_CHECKSUM_EN
               // first header byte restarts the running sum
               sum_d = (hdr_cnt_q == '0) ? in_data : sum_q + in_data;
`endif
               if (hdr_cnt_q == HC_W'(HDR_BYTES - 1)) begin
                  hdr_cnt_d = '0;
                  state_d   = S_CHECK;
               end else begin
                  hdr_cnt_d = hdr_cnt_q + 1'b1;
               end
            end
         end

         S_CHECK: begin
            if (hdr_bad) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else begin
               state_d      = S_PIX;
               pix_cnt_d    = '0;
               last_idx_d   = total_w - 32'd1;
               cfg_width_d  = hw_q;
               cfg_height_d = hh_q;
               cfg_scale_d  = hs_q;
               cfg_mode_d   = hm_q;
            end
         end

         S_PIX: begin
            if (xfer) begin
               mem_we_d   = 1'b1;
               mem_addr_d = pix_cnt_q;
               mem_data_d = in_data;
               pix_cnt_d  = pix_cnt_q + 1'b1;
`ifdef IMAGE_LOADER_CHECKSUM_EN
               sum_d      = sum_q + in_data;
`endif
               if (32'(pix_cnt_q) == last_idx_q) begin
`ifdef IMAGE_LOADER_CHECKSUM_EN
                  state_d = S_CKSUM;
`else
                  state_d = S_START;
`endif
               end
            end
         end

`ifdef IMAGE_LOADER_CHECKSUM_EN
         S_CKSUM: begin
            if (xfer) begin
               if (8'(sum_q + in_data) == 8'h00) begin
                  state_d = S_START;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
         end
`endif

         // start/done are registered, so each pulse appears one cycle after
         // its state: write cycle, then start_proc, then load_done
         S_START: begin
            start_d = 1'b1;
            state_d = S_DONE;
         end

         S_DONE: begin
            done_d    = 1'b1;
            state_d   = S_HDR;
            hdr_cnt_d = '0;
         end

         S_ERR: begin
            if (clr_err) begin
               err_d     = 1'b0;
               state_d   = S_HDR;
               hdr_cnt_d = '0;
            end
         end

         default: begin
            state_d   = S_HDR;
            hdr_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_HDR;
         hdr_cnt_q    <= '0;
         pix_cnt_q    <= '0;
         last_idx_q   <= '0;
         hw_q         <= '0;
         hh_q         <= '0;
         hs_q         <= '0;
         hm_q         <= '0;
         cfg_width_q  <= '0;
         cfg_height_q <= '0;
         cfg_scale_q  <= '0;
         cfg_mode_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         start_q      <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         hdr_cnt_q    <= hdr_cnt_d;
         pix_cnt_q    <= pix_cnt_d;
         last_idx_q   <= last_idx_d;
         hw_q         <= hw_d;
         hh_q         <= hh_d;
         hs_q         <= hs_d;
         hm_q         <= hm_d;
         cfg_width_q  <= cfg_width_d;
         cfg_height_q <= cfg_height_d;
         cfg_scale_q  <= cfg_scale_d;
         cfg_mode_q   <= cfg_mode_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         start_q      <= start_d;
         done_q       <= done_d;
         err_q        <= err_d;
`ifdef IMAGE_LOADER_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_data_out = mem_data_q;
   assign cfg_width    = cfg_width_q;
   assign cfg_height   = cfg_height_q;
   assign cfg_scale    = cfg_scale_q;
   assign cfg_mode     = cfg_mode_q;
   assign start_proc   = start_q;
   assign load_done    = done_q;
   assign err          = err_q;

endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
- Upstream stage of the bilinear downscaler control unit.
- Accepts a byte stream (host/UART side) consisting of a 7-byte header followed by width*height source pixels.
- Writes the pixels row-major into shared image memory starting at 0x00000, latches the configuration, then fires a one-cycle start pulse to the control unit.
- Drives the memory only while the control unit is idle; the external memory mux selects the loader when cu_busy=0.

Parameters:
- ADDR_W, 19, memory address width
- MAX_PIXELS, 262144, input region size; output region begins at 0x40000
- HDR_BYTES, 7, header length: width L/H, height L/H, scale L/H, mode

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte; transfer when in_valid&&in_ready
- cu_busy  in  1  control unit busy
- mem_we  out  1  memory write enable
- mem_addr  out  19  memory address
- mem_data_out  out  8  memory write data
- cfg_width  out  16  latched image width
- cfg_height  out  16  latched image height
- cfg_scale  out  16  latched scale (0x0080 = 1/2)
- cfg_mode  out  8  latched mode (0=sequential, 1=SIMD)
- start_proc  out  1  one-cycle start pulse to control unit
- load_done  out  1  one-cycle pulse, image loaded
- err  out  1  sticky error flag
- clr_err  in  1  clears err and returns to HDR

Behaviour:
- Reset (rst=1 at posedge): state=HDR, hdr_cnt=0, pix_cnt=0. All outputs are 0, including cfg_*. A partially loaded image stays in memory.
- in_ready = (state==HDR || state==PIX) && !cu_busy. It is combinational from state and cu_busy.
- HDR:
  - Each transfer stores a byte at header index hdr_cnt. Multi-byte fields are little-endian.
  - After byte index 6, go to CHECK.
  - cfg_* outputs update only on the CHECK->PIX transition.
- CHECK (1 cycle): compute total=width*height as 32 bits.
  - Error if width<2, height<2, width odd, height odd, total>MAX_PIXELS, scale not in {0x0080,0x0100}, or mode>1.
  - On error: go to ERR. Otherwise go to PIX with pix_cnt=0.
- PIX: each transfer produces, on the next posedge, mem_we=1, mem_addr=pix_cnt, mem_data_out=in_data, and pix_cnt+1.
  - mem_we=0 on cycles with no transfer; no bubble insertion.
  - After the transfer with pix_cnt==total-1, go to START.
- START (1 cycle): mem_we=0, start_proc=1. Next state is DONE.
- DONE (1 cycle): start_proc=0, load_done=1. Next state is HDR with hdr_cnt=0.
- ERR: err=1 and in_ready=0.
  - clr_err=1 sets err=0 and goes to HDR on the next cycle.
  - In other states clr_err is ignored.
- cu_busy rising mid-PIX: in_ready drops the same cycle and no write occurs. Loading resumes when cu_busy falls; no bytes are lost.
- Simultaneous rst and clr_err: rst wins.
- Throughput: 1 byte/cycle. Last accepted pixel -> start_proc high 2 cycles later (write cycle, then START).

Optional Feature:
- Macro: IMAGE_LOADER_CHECKSUM_EN.
- Enabled:
  - Maintain an 8-bit running sum (mod 256) of the header bytes and pixel bytes.
  - After the last pixel, enter CKSUM, where in_ready follows the same rule as PIX. Accept one trailing byte.
  - If sum+byte==0x00 (mod 256), go to START. Otherwise go to ERR and no start_proc is issued.
- Disabled: no trailing byte; the last pixel goes directly to START.

Test Plan:
- Header 04 00 02 00 80 00 00, then pixels 0x10..0x17 -> mem writes addr 0..7 with data 0x10..0x17 in order. cfg_width=4, cfg_height=2, cfg_scale=0x0080, cfg_mode=0. start_proc pulses exactly once, 2 cycles after the last byte. load_done follows 1 cycle later.
- Header width=3 (03 00 02 00 80 00 00) -> err=1 after CHECK, in_ready=0, no mem_we. clr_err -> HDR; a valid header is then accepted.
- Header 00 02 00 02 80 00 01 (512x512, total=0x40000) -> accepted; the final write goes to addr 0x3FFFF. Width=0x0202, height=0x0200 -> err.
- cu_busy=1 asserted mid-PIX for 5 cycles while in_valid=1 -> in_ready=0 and mem_we=0 for those 5 cycles. The byte sequence continues unbroken afterwards.
- rst pulsed after 3 pixels of a 4x2 load -> all outputs 0 and state HDR. A fresh full load completes normally.
- CHECKSUM_EN with a 4x2 image and a correct trailing byte -> start_proc fires. With the trailing byte off by one -> err=1 and no start_proc.
